// File: rtl/fetch_pc_gen_pkg.sv
// Shared frontend definitions for the fetch-PC generator: PC source encoding and
// architectural defaults.
package fetch_pc_gen_pkg;

    localparam int          PKG_XLEN     = 32;
    localparam logic [31:0] PKG_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        PC_SEL_SEQ   = 2'd0,
        PC_SEL_PRED  = 2'd1,
        PC_SEL_RAS   = 2'd2,
        PC_SEL_REDIR = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_gen_ras.sv
// Circular return-address stack. A simultaneous pop and push replaces the top entry
// in place; on overflow the oldest entry is overwritten.
module return_addr_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, wr_ptr_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en_s;
    logic             do_pop_s;

    assign top_data = mem_q[ptr_q];
    assign empty    = (cnt_q == CNT_W'(0));
    assign full     = (cnt_q == CNT_W'(DEPTH));

    // Next pointer, count and write slot for the requested operation.
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wr_en_s  = 1'b0;
        wr_ptr_s = ptr_q;
        do_pop_s = pop & (cnt_q != CNT_W'(0));
        if (push && do_pop_s) begin
            wr_en_s = 1'b1;
        end else if (push) begin
            ptr_d    = ptr_q + PTR_W'(1);
            wr_ptr_s = ptr_q + PTR_W'(1);
            wr_en_s  = 1'b1;
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (do_pop_s) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stack state and entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= PTR_W'(0);
            cnt_q <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= XLEN'(0);
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en_s) begin
                mem_q[wr_ptr_s] <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: prioritised next-PC select (redirect > RAS > predictor > sequential),
// fetch-valid register and lane mask for an aligned fetch block.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int              XLEN        = PKG_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = PKG_RESET_PC,
    parameter int              FETCH_WIDTH = 2,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pc_en,
    input  logic                   pc_stall,
    input  logic                   redir_valid,
    input  logic [XLEN-1:0]        redir_target,
    input  logic                   pred_taken,
    input  logic [XLEN-1:0]        pred_target,
    input  logic                   dec_call,
    input  logic                   dec_ret,
    input  logic [XLEN-1:0]        call_ret_addr,
    input  logic                   fetch_ready,
    output logic                   fetch_valid,
    output logic [XLEN-1:0]        pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output pc_sel_e                pc_sel,
    output logic                   ras_empty
);
    localparam logic [XLEN-1:0] BLK_BYTES = XLEN'(FETCH_WIDTH * INSTR_BYTES);

    // Lanes at or after the lane addressed by pc within its block are valid.
    function automatic logic [FETCH_WIDTH-1:0] lane_mask(input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] lane;
        lane = (addr >> 2) & XLEN'(FETCH_WIDTH - 1);
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_mask[i] = (XLEN'(i) >= lane);
        end
    endfunction

    logic                   fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [FETCH_WIDTH-1:0] fetch_mask_q, fetch_mask_d;
    pc_sel_e                pc_sel_q, pc_sel_d;

    logic            advance_s, load_s, ras_push_s, ras_pop_s;
    logic [XLEN-1:0] seq_pc_s, tgt_s, ras_top_s;
    pc_sel_e         sel_s;
    logic            ras_full_s;

    return_addr_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (call_ret_addr),
        .top_data  (ras_top_s),
        .empty     (ras_empty),
        .full      (ras_full_s)
    );

    // Next-PC source selection and register next-state.
    always_comb begin
        advance_s = fetch_valid_q & fetch_ready & pc_en & ~pc_stall;
        seq_pc_s  = (pc_q & ~(BLK_BYTES - XLEN'(1))) + BLK_BYTES;
        if (redir_valid) begin
            sel_s = PC_SEL_REDIR;
            tgt_s = redir_target;
        end else if (dec_ret && !ras_empty) begin
            sel_s = PC_SEL_RAS;
            tgt_s = ras_top_s;
        end else if (pred_taken) begin
            sel_s = PC_SEL_PRED;
            tgt_s = pred_target;
        end else begin
            sel_s = PC_SEL_SEQ;
            tgt_s = seq_pc_s;
        end
        // A redirect lands even while stalled or while the I-cache is busy.
        load_s = redir_valid | advance_s;
        if (load_s) begin
            pc_d     = tgt_s & ~XLEN'(3);
            pc_sel_d = sel_s;
        end else begin
            pc_d     = pc_q;
            pc_sel_d = pc_sel_q;
        end
        fetch_mask_d  = lane_mask(pc_d);
        fetch_valid_d = pc_en;
        ras_push_s    = advance_s & ~redir_valid & dec_call;
        ras_pop_s     = advance_s & ~redir_valid & dec_ret;
    end

    // Fetch request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_valid_q <= 1'b0;
            pc_q          <= RESET_PC;
            fetch_mask_q  <= lane_mask(RESET_PC);
            pc_sel_q      <= PC_SEL_SEQ;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            pc_q          <= pc_d;
            fetch_mask_q  <= fetch_mask_d;
            pc_sel_q      <= pc_sel_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign pc          = pc_q;
    assign fetch_mask  = fetch_mask_q;
    assign pc_sel      = pc_sel_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen (XLEN=32, FETCH_WIDTH=2, RAS_DEPTH=4) with
// hand-computed expected values.
module tb_fetch_pc_gen;
    import fetch_pc_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pc_en, pc_stall, redir_valid, pred_taken, dec_call, dec_ret, fetch_ready;
    logic [31:0] redir_target, pred_target, call_ret_addr;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [1:0]  fetch_mask;
    pc_sel_e     pc_sel;
    logic        ras_empty;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] ret_exp [4];

    fetch_pc_gen #(.XLEN(32), .RESET_PC(32'h0000_0000), .FETCH_WIDTH(2), .RAS_DEPTH(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_en         (pc_en),
        .pc_stall      (pc_stall),
        .redir_valid   (redir_valid),
        .redir_target  (redir_target),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .dec_call      (dec_call),
        .dec_ret       (dec_ret),
        .call_ret_addr (call_ret_addr),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .pc            (pc),
        .fetch_mask    (fetch_mask),
        .pc_sel        (pc_sel),
        .ras_empty     (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; pc_en = 1'b1; pc_stall = 1'b0; redir_valid = 1'b0; pred_taken = 1'b0;
        dec_call = 1'b0; dec_ret = 1'b0; fetch_ready = 1'b1;
        redir_target = 32'h0; pred_target = 32'h0; call_ret_addr = 32'h0;
        ret_exp[0] = 32'h500; ret_exp[1] = 32'h400; ret_exp[2] = 32'h300; ret_exp[3] = 32'h200;

        // Reset state
        repeat (3) tick();
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_valid", 32'(fetch_valid), 32'h0);
        check_val("rst_ras_empty", 32'(ras_empty), 32'h1);
        check_val("rst_sel", 32'(pc_sel), 32'(PC_SEL_SEQ));
        check_val("rst_mask", 32'(fetch_mask), 32'h3);
        @(negedge clk);
        reset_n = 1'b1;

        // Sequential stepping after release
        tick();
        check_val("rel_valid", 32'(fetch_valid), 32'h1);
        check_val("rel_pc", pc, 32'h0);
        tick();
        check_val("seq_pc8", pc, 32'h8);
        tick();
        check_val("seq_pc16", pc, 32'h10);
        check_val("seq_sel", 32'(pc_sel), 32'(PC_SEL_SEQ));

        // Mid-block entry, low-bit clearing and address wrap
        redir_valid = 1'b1; redir_target = 32'h0000_0007;
        tick();
        check_val("mid_pc", pc, 32'h4);
        check_val("mid_mask", 32'(fetch_mask), 32'h2);
        check_val("mid_sel", 32'(pc_sel), 32'(PC_SEL_REDIR));
        redir_valid = 1'b0;
        tick();
        check_val("mid_next_pc", pc, 32'h8);
        check_val("mid_next_mask", 32'(fetch_mask), 32'h3);
        redir_valid = 1'b1; redir_target = 32'hFFFF_FFF8;
        tick();
        check_val("top_pc", pc, 32'hFFFF_FFF8);
        redir_valid = 1'b0;
        tick();
        check_val("wrap_pc", pc, 32'h0);

        // Redirect overrides stall and not-ready
        pc_stall = 1'b1; fetch_ready = 1'b0; redir_valid = 1'b1; redir_target = 32'h400;
        tick();
        check_val("redir_pc", pc, 32'h400);
        check_val("redir_sel", 32'(pc_sel), 32'(PC_SEL_REDIR));
        redir_valid = 1'b0;
        repeat (2) tick();
        check_val("stall_hold_pc", pc, 32'h400);
        pc_stall = 1'b0; fetch_ready = 1'b1;
        tick();
        check_val("unstall_pc", pc, 32'h408);

        // Five calls into a four-deep stack, then five returns
        dec_call = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            call_ret_addr = 32'(k) * 32'h100;
            tick();
        end
        check_val("call_ras_empty", 32'(ras_empty), 32'h0);
        dec_call = 1'b0; dec_ret = 1'b1; pred_taken = 1'b1; pred_target = 32'h900;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val($sformatf("ret%0d_pc", k), pc, ret_exp[k]);
            check_val($sformatf("ret%0d_sel", k), 32'(pc_sel), 32'(PC_SEL_RAS));
        end
        check_val("ret_drained", 32'(ras_empty), 32'h1);
        tick();
        check_val("ret5_pc", pc, 32'h900);
        check_val("ret5_sel", 32'(pc_sel), 32'(PC_SEL_PRED));
        dec_ret = 1'b0;

        // I-cache back-pressure with a taken prediction and a pending call
        fetch_ready = 1'b0; pred_target = 32'h1000; dec_call = 1'b1; call_ret_addr = 32'hA00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("bp%0d_pc", k), pc, 32'h900);
            check_val($sformatf("bp%0d_valid", k), 32'(fetch_valid), 32'h1);
            check_val($sformatf("bp%0d_ras", k), 32'(ras_empty), 32'h1);
        end
        fetch_ready = 1'b1;
        tick();
        check_val("bp_adv_pc", pc, 32'h1000);
        check_val("bp_adv_ras", 32'(ras_empty), 32'h0);
        repeat (2) tick();
        dec_call = 1'b0; pred_taken = 1'b0;

        // Asynchronous reset mid-stream with three RAS entries
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_pc", pc, 32'h0);
        check_val("arst_valid", 32'(fetch_valid), 32'h0);
        check_val("arst_ras_empty", 32'(ras_empty), 32'h1);
        check_val("arst_sel", 32'(pc_sel), 32'(PC_SEL_SEQ));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_val("arst_rel_valid", 32'(fetch_valid), 32'h1);
        dec_ret = 1'b1;
        tick();
        check_val("arst_ret_pc", pc, 32'h8);
        check_val("arst_ret_sel", 32'(pc_sel), 32'(PC_SEL_SEQ));
        dec_ret = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
